ram_lsu_master: RTL and testbench

- Initiator for one port of the team's byte-enable dual-port block RAM. That port has 1-cycle read latency, takes word-aligned rows and byte enables, and aborts simulation on non-aligned or 0111 patterns.
- Turns core load/store requests (byte/half/word, signed/unsigned, any alignment) into a legal sequence of aligned RAM accesses.
- Merges the returned bytes and produces a single extended response.
- Sits between the core's memory stage and the RAM port.

---
 rtl/ram_lsu_master.sv | 273 +++++++++++++++++++++++++++
 tb/tb_ram_lsu_master.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_lsu_master.sv
// Load/store initiator for one byte-enable block RAM port: splits, merges and extends accesses.
// Define LSU_MISALIGN_SPLIT_EN to split row-crossing requests; otherwise they are rejected.

module ram_lsu_master #(
  parameter int unsigned SCALE = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [1:0]       req_size,
  input  logic             req_unsigned,
  input  logic [SCALE-1:0] req_addr,
  input  logic [31:0]      req_wdata,
  output logic             rsp_valid,
  output logic [31:0]      rsp_rdata,
  output logic             rsp_err,
  output logic             ram_oe,
  output logic [SCALE-1:0] ram_addr,
  output logic [31:0]      ram_wdata,
  output logic [3:0]       ram_we,
  input  logic [31:0]      ram_rdata
);

  localparam int unsigned RW = SCALE - 2;

`ifdef LSU_MISALIGN_SPLIT_EN
  localparam int unsigned NumAcc = 3;
`else
  localparam int unsigned NumAcc = 1;
`endif

  typedef enum logic [1:0] {StIdle, StAcc, StDrain, StResp} state_e;

  function automatic logic [31:0] lane_bits(input logic [3:0] m);
    return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
  endfunction

  state_e state_q, state_d;

  logic          accept;
  logic [3:0]    size_mask;
  logic [7:0]    span;
  logic [5:0]    req_sh;
  logic [RW-1:0] row0;
  logic [31:0]   wrot;
  logic          p_err;
  logic [3:0]    p_mask [NumAcc];

  // Latched request context
  logic          we_q, uns_q, err_q;
  logic [1:0]    size_q, k_q;
  logic [3:0]    mask_q [NumAcc];

`ifdef LSU_MISALIGN_SPLIT_EN
  logic [1:0]    p_cnt;
  logic [1:0]    acc_idx_q, acc_cnt_q, nxt_idx;
  logic [3:0]    nxt_mask;
  logic [RW-1:0] row1_q;
  logic [31:0]   wrot_q;
`endif

  // Load assembly
  logic [3:0]    cur_mask, rd_mask_q, rd_mask_d;
  logic          last_acc;
  logic [31:0]   data_q, data_d, merged, ordered, load_ext;
  logic [5:0]    k_sh;

  // Registered outputs
  logic             req_ready_q, req_ready_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_err_q, rsp_err_d;
  logic [31:0]      rsp_rdata_q, rsp_rdata_d;
  logic             ram_oe_q, ram_oe_d;
  logic [SCALE-1:0] ram_addr_q, ram_addr_d;
  logic [31:0]      ram_wdata_q, ram_wdata_d;
  logic [3:0]       ram_we_q, ram_we_d;

  assign accept = req_valid && req_ready_q;

  // Access plan for the offered request; lanes past byte 3 belong to the next row.
  always_comb begin
    case (req_size)
      2'd0:    size_mask = 4'b0001;
      2'd1:    size_mask = 4'b0011;
      2'd2:    size_mask = 4'b1111;
      default: size_mask = 4'b0000;
    endcase
    span      = {4'b0000, size_mask} << req_addr[1:0];
    req_sh    = {1'b0, req_addr[1:0], 3'b000};
    wrot      = (req_wdata << req_sh) | (req_wdata >> (6'd32 - req_sh));
    row0      = req_addr[SCALE-1:2];
    p_mask[0] = span[3:0];
`ifdef LSU_MISALIGN_SPLIT_EN
    p_err     = (req_size == 2'd3);
    p_mask[1] = span[7:4];
    p_mask[2] = 4'b0000;
    p_cnt     = 2'd1;
    // The RAM port rejects 0111, so that pattern goes out as 0011 then 0100.
    if (span[7:4] == 4'b0111) begin
      p_mask[1] = 4'b0011;
      p_mask[2] = 4'b0100;
      p_cnt     = 2'd3;
    end else if (span[7:4] != 4'b0000) begin
      p_cnt = 2'd2;
    end
`else
    p_err = (req_size == 2'd3) || (span[7:4] != 4'b0000);
`endif
  end

  always_comb begin
`ifdef LSU_MISALIGN_SPLIT_EN
    cur_mask = mask_q[acc_idx_q];
    last_acc = (acc_idx_q == acc_cnt_q - 2'd1);
    nxt_idx  = acc_idx_q + 2'd1;
    nxt_mask = mask_q[nxt_idx];
`else
    cur_mask = mask_q[0];
    last_acc = 1'b1;
`endif
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = p_err ? StDrain : StAcc;
      StAcc:   if (last_acc) state_d = StDrain;
      StDrain: state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Read data from the previous cycle's access lands in its own lanes only.
  always_comb begin
    merged    = (data_q & ~lane_bits(rd_mask_q)) | (ram_rdata & lane_bits(rd_mask_q));
    data_d    = accept ? 32'h0 : merged;
    rd_mask_d = (state_q == StAcc && !we_q) ? cur_mask : 4'b0000;
    k_sh      = {1'b0, k_q, 3'b000};
    ordered   = (merged >> k_sh) | (merged << (6'd32 - k_sh));
    case (size_q)
      2'd0:    load_ext = uns_q ? {24'h0, ordered[7:0]} : {{24{ordered[7]}}, ordered[7:0]};
      2'd1:    load_ext = uns_q ? {16'h0, ordered[15:0]} : {{16{ordered[15]}}, ordered[15:0]};
      default: load_ext = ordered;
    endcase
  end

  // Output next-state values
  always_comb begin
    req_ready_d = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = 32'h0;
    ram_oe_d    = 1'b0;
    ram_addr_d  = '0;
    ram_wdata_d = 32'h0;
    ram_we_d    = 4'b0000;
    unique case (state_q)
      StIdle: begin
        if (!accept) begin
          req_ready_d = 1'b1;
        end else if (!p_err) begin
          ram_oe_d    = 1'b1;
          ram_addr_d  = {row0, 2'b00};
          ram_we_d    = req_we ? p_mask[0] : 4'b0000;
          ram_wdata_d = req_we ? (wrot & lane_bits(p_mask[0])) : 32'h0;
        end
      end
      StAcc: begin
`ifdef LSU_MISALIGN_SPLIT_EN
        if (!last_acc) begin
          ram_oe_d    = 1'b1;
          ram_addr_d  = {row1_q, 2'b00};
          ram_we_d    = we_q ? nxt_mask : 4'b0000;
          ram_wdata_d = we_q ? (wrot_q & lane_bits(nxt_mask)) : 32'h0;
        end
`endif
      end
      StDrain: begin
        rsp_valid_d = 1'b1;
        rsp_err_d   = err_q;
        rsp_rdata_d = (err_q || we_q) ? 32'h0 : load_ext;
      end
      StResp: req_ready_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_q      <= 1'b0;
      uns_q     <= 1'b0;
      err_q     <= 1'b0;
      size_q    <= 2'd0;
      k_q       <= 2'd0;
      data_q    <= 32'h0;
      rd_mask_q <= 4'b0000;
      for (int i = 0; i < NumAcc; i++) mask_q[i] <= 4'b0000;
`ifdef LSU_MISALIGN_SPLIT_EN
      acc_idx_q <= 2'd0;
      acc_cnt_q <= 2'd0;
      row1_q    <= '0;
      wrot_q    <= 32'h0;
`endif
    end else begin
      data_q    <= data_d;
      rd_mask_q <= rd_mask_d;
      if (accept) begin
        we_q   <= req_we;
        uns_q  <= req_unsigned;
        err_q  <= p_err;
        size_q <= req_size;
        k_q    <= req_addr[1:0];
        for (int i = 0; i < NumAcc; i++) mask_q[i] <= p_mask[i];
`ifdef LSU_MISALIGN_SPLIT_EN
        acc_idx_q <= 2'd0;
        acc_cnt_q <= p_cnt;
        row1_q    <= row0 + RW'(1);
        wrot_q    <= wrot;
`endif
      end
`ifdef LSU_MISALIGN_SPLIT_EN
      else if (state_q == StAcc && !last_acc) begin
        acc_idx_q <= nxt_idx;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'h0;
      ram_oe_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= 32'h0;
      ram_we_q    <= 4'b0000;
    end else begin
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      ram_oe_q    <= ram_oe_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      ram_we_q    <= ram_we_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;
  assign ram_oe    = ram_oe_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign ram_we    = ram_we_q;

endmodule

// File: tb/tb_ram_lsu_master.sv
// Directed bench for ram_lsu_master against a byte-enable RAM model with 1-cycle read latency.
// Expectations follow LSU_MISALIGN_SPLIT_EN when that macro is defined for the build.

module tb_ram_lsu_master;

  localparam int unsigned SCALE = 10;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]       req_size;
  logic [SCALE-1:0] req_addr;
  logic [31:0]      req_wdata;
  logic             rsp_valid, rsp_err, ram_oe;
  logic [31:0]      rsp_rdata, ram_wdata, ram_rdata;
  logic [SCALE-1:0] ram_addr;
  logic [3:0]       ram_we;

  int vectors = 0;
  int miscompares = 0;
  int illegal = 0;
  logic mem_clr;
  logic [31:0] mem [256];

  // Per-request observations
  int          acc_n, rsp_rel;
  logic [9:0]  acc_addr [4];
  logic [3:0]  acc_we [4];
  logic [31:0] acc_wd [4];
  int          acc_rel [4];
  logic [31:0] rsp_data;
  logic        rsp_e, rdy_rel1, rdy_after, rsp_after;

  ram_lsu_master #(.SCALE(SCALE)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .ram_oe       (ram_oe),
    .ram_addr     (ram_addr),
    .ram_wdata    (ram_wdata),
    .ram_we       (ram_we),
    .ram_rdata    (ram_rdata)
  );

  always #5 clk = ~clk;

  // RAM port model; illegal patterns are tallied instead of aborting.
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
      ram_rdata <= 32'h0;
    end else if (ram_oe) begin
      if (ram_addr[1:0] != 2'b00 || ram_we == 4'b0111) illegal <= illegal + 1;
      ram_rdata <= mem[ram_addr[9:2]];
      for (int b = 0; b < 4; b++)
        if (ram_we[b]) mem[ram_addr[9:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
    end else if (ram_we != 4'b0000) begin
      illegal <= illegal + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Called just after a negedge; returns just after a negedge.
  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [9:0] addr, input logic [31:0] wd);
    int guard;
    bit got;
    acc_n = 0; rsp_rel = -1; rsp_data = 32'h0; rsp_e = 1'b0;
    for (int i = 0; i < 4; i++) begin
      acc_addr[i] = '0; acc_we[i] = '0; acc_wd[i] = '0; acc_rel[i] = -1;
    end
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wd;
    guard = 0;
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk("accept_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    rdy_rel1 = req_ready;
    got = 1'b0;
    for (int rel = 1; rel <= 12 && !got; rel++) begin
      if (rel > 1) @(negedge clk);
      if (ram_oe && acc_n < 4) begin
        acc_addr[acc_n] = ram_addr; acc_we[acc_n] = ram_we;
        acc_wd[acc_n] = ram_wdata; acc_rel[acc_n] = rel;
        acc_n++;
      end
      if (rsp_valid) begin
        got = 1'b1; rsp_rel = rel; rsp_data = rsp_rdata; rsp_e = rsp_err;
      end
    end
    @(negedge clk);
    rdy_after = req_ready;
    rsp_after = rsp_valid;
  endtask

  task automatic exp_rsp(input string tag, input int n, input int rel,
                         input logic [31:0] data, input logic err);
    chk({tag, "_nacc"}, 32'(acc_n), 32'(n));
    chk({tag, "_rsp_cycle"}, 32'(rsp_rel), 32'(rel));
    chk({tag, "_rdata"}, rsp_data, data);
    chk({tag, "_err"}, 32'(rsp_e), 32'(err));
    chk({tag, "_busy"}, 32'(rdy_rel1), 32'd0);
    chk({tag, "_ready_after"}, 32'(rdy_after), 32'd1);
    chk({tag, "_pulse"}, 32'(rsp_after), 32'd0);
  endtask

  task automatic exp_acc(input string tag, input int i, input logic [9:0] a,
                         input logic [3:0] we, input int rel);
    chk($sformatf("%s_acc%0d_addr", tag, i), 32'(acc_addr[i]), 32'(a));
    chk($sformatf("%s_acc%0d_we", tag, i), 32'(acc_we[i]), 32'(we));
    chk($sformatf("%s_acc%0d_cycle", tag, i), 32'(acc_rel[i]), 32'(rel));
  endtask

  task automatic exp_wd(input string tag, input int i, input logic [31:0] d);
    chk($sformatf("%s_acc%0d_wdata", tag, i), acc_wd[i], d);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = 32'h0; mem_clr = 1'b1;
    repeat (3) @(negedge clk);
    mem_clr = 1'b0;
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_oe", 32'(ram_oe), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_ram_addr", 32'(ram_addr), 32'h0);
    chk("rst_ram_wdata", ram_wdata, 32'h0);
    chk("rst_ram_we", 32'(ram_we), 32'h0);
    rst = 1'b1;
    #1 chk("rel_ready_pre_edge", 32'(req_ready), 32'd0);
    @(negedge clk);
    chk("rel_ready_post_edge", 32'(req_ready), 32'd1);

    // Aligned word store and load
    do_req(1'b1, 2'd2, 1'b0, 10'h010, 32'hDEADBEEF);
    exp_rsp("st_w10", 1, 3, 32'h0, 1'b0);
    exp_acc("st_w10", 0, 10'h010, 4'b1111, 1);
    exp_wd("st_w10", 0, 32'hDEADBEEF);
    do_req(1'b0, 2'd2, 1'b0, 10'h010, 32'h0);
    exp_rsp("ld_w10", 1, 3, 32'hDEADBEEF, 1'b0);
    exp_acc("ld_w10", 0, 10'h010, 4'b0000, 1);

    // Byte store, signed/unsigned byte and half loads
    do_req(1'b1, 2'd0, 1'b0, 10'h013, 32'h00000080);
    exp_rsp("st_b13", 1, 3, 32'h0, 1'b0);
    exp_acc("st_b13", 0, 10'h010, 4'b1000, 1);
    exp_wd("st_b13", 0, 32'h80000000);
    do_req(1'b0, 2'd0, 1'b0, 10'h013, 32'h0);
    exp_rsp("ld_bs13", 1, 3, 32'hFFFFFF80, 1'b0);
    exp_acc("ld_bs13", 0, 10'h010, 4'b0000, 1);
    do_req(1'b0, 2'd0, 1'b1, 10'h013, 32'h0);
    exp_rsp("ld_bu13", 1, 3, 32'h00000080, 1'b0);
    do_req(1'b0, 2'd1, 1'b0, 10'h012, 32'h0);
    exp_rsp("ld_hs12", 1, 3, 32'hFFFF80AD, 1'b0);
    do_req(1'b0, 2'd1, 1'b1, 10'h010, 32'h0);
    exp_rsp("ld_hu10", 1, 3, 32'h0000BEEF, 1'b0);

    // Illegal size
    do_req(1'b0, 2'd3, 1'b0, 10'h020, 32'h0);
    exp_rsp("ld_sz3", 0, 2, 32'h0, 1'b1);
    do_req(1'b1, 2'd3, 1'b0, 10'h020, 32'h12345678);
    exp_rsp("st_sz3", 0, 2, 32'h0, 1'b1);

`ifdef LSU_MISALIGN_SPLIT_EN
    do_req(1'b1, 2'd2, 1'b0, 10'h007, 32'h11223344);
    exp_rsp("st_w07", 3, 5, 32'h0, 1'b0);
    exp_acc("st_w07", 0, 10'h004, 4'b1000, 1);
    exp_acc("st_w07", 1, 10'h008, 4'b0011, 2);
    exp_acc("st_w07", 2, 10'h008, 4'b0100, 3);
    exp_wd("st_w07", 0, 32'h44000000);
    exp_wd("st_w07", 1, 32'h00002233);
    exp_wd("st_w07", 2, 32'h00110000);
    do_req(1'b0, 2'd2, 1'b0, 10'h007, 32'h0);
    exp_rsp("ld_w07", 3, 5, 32'h11223344, 1'b0);
    exp_acc("ld_w07", 2, 10'h008, 4'b0000, 3);
    do_req(1'b0, 2'd2, 1'b0, 10'h005, 32'h0);
    exp_rsp("ld_w05", 2, 4, 32'h33440000, 1'b0);
    exp_acc("ld_w05", 1, 10'h008, 4'b0000, 2);
    do_req(1'b1, 2'd1, 1'b0, 10'h3FF, 32'h0000ABCD);
    exp_rsp("st_h3ff", 2, 4, 32'h0, 1'b0);
    exp_acc("st_h3ff", 0, 10'h3FC, 4'b1000, 1);
    exp_acc("st_h3ff", 1, 10'h000, 4'b0001, 2);
    exp_wd("st_h3ff", 0, 32'hCD000000);
    exp_wd("st_h3ff", 1, 32'h000000AB);
    do_req(1'b0, 2'd1, 1'b0, 10'h3FF, 32'h0);
    exp_rsp("ld_h3ff", 2, 4, 32'hFFFFABCD, 1'b0);
    exp_acc("ld_h3ff", 1, 10'h000, 4'b0000, 2);
`else
    do_req(1'b0, 2'd2, 1'b0, 10'h002, 32'h0);
    exp_rsp("ld_w02", 0, 2, 32'h0, 1'b1);
    do_req(1'b1, 2'd2, 1'b0, 10'h007, 32'h11223344);
    exp_rsp("st_w07", 0, 2, 32'h0, 1'b1);
    do_req(1'b1, 2'd1, 1'b0, 10'h3FF, 32'h0000ABCD);
    exp_rsp("st_h3ff", 0, 2, 32'h0, 1'b1);
    do_req(1'b1, 2'd1, 1'b0, 10'h3FE, 32'h0000ABCD);
    exp_rsp("st_h3fe", 1, 3, 32'h0, 1'b0);
    exp_acc("st_h3fe", 0, 10'h3FC, 4'b1100, 1);
    exp_wd("st_h3fe", 0, 32'hABCD0000);
    do_req(1'b0, 2'd1, 1'b0, 10'h3FE, 32'h0);
    exp_rsp("ld_h3fe", 1, 3, 32'hFFFFABCD, 1'b0);
`endif

    // Reset in the middle of a store
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
    req_wdata = 32'hCAFEF00D;
`ifdef LSU_MISALIGN_SPLIT_EN
    req_addr = 10'h00B;
`else
    req_addr = 10'h020;
`endif
    chk("mid_accept_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
`ifdef LSU_MISALIGN_SPLIT_EN
    @(negedge clk);
`endif
    chk("mid_oe_active", 32'(ram_oe), 32'd1);
    #1 rst = 1'b0;
    #1 chk("mid_oe_drop", 32'(ram_oe), 32'd0);
    chk("mid_ready_low", 32'(req_ready), 32'd0);
    seen = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    rst = 1'b1;
    @(negedge clk);
    if (rsp_valid) seen = 1'b1;
    chk("post_rst_ready", 32'(req_ready), 32'd1);
    repeat (3) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    chk("post_rst_no_rsp", 32'(seen), 32'd0);
    do_req(1'b0, 2'd2, 1'b0, 10'h010, 32'h0);
    exp_rsp("post_rst_ld", 1, 3, 32'h80ADBEEF, 1'b0);
    exp_acc("post_rst_ld", 0, 10'h010, 4'b0000, 1);

    chk("ram_port_legal", 32'(illegal), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
